// File: rtl/dp_job_scheduler.sv
// ---------------------------------------------------------------------------
// dp_job_scheduler
//
// Shares one four-stage load/mux datapath between NREQ requesting units.
// A round-robin arbiter picks one requester. The block then steps the
// datapath through load stages S1..S4, holding each stage for STAGE_CYC
// clocks, and pulses that requester's done bit for one cycle in FIN.
// This block is the only driver of the datapath control lines.
//
// Parameters
//   NREQ       number of requesters (2..8)
//   STAGE_CYC  clocks each load stage is held (1..15)
//
// Ports
//   clk    in   1     rising-edge clock
//   rst_n  in   1     asynchronous, active-low reset
//   req    in   NREQ  per-requester job request; held until done, dropped to abort
//   grant  out  NREQ  one-hot owner of the datapath, zero when idle
//   busy   out  1     high whenever a job is in progress (state != IDLE)
//   sel1   out  1     stage-1 load enable
//   sel2   out  1     stage-2 load enable
//   mux1   out  1     stage-2 operand mux select
//   sel3   out  1     stage-3 load enable
//   sel4   out  1     stage-4 load enable
//   mux2   out  1     stage-4 operand mux select
//   done   out  NREQ  one-cycle completion pulse to the granted requester
//
// Every output comes straight from a flop. The flops are loaded from the
// decode of the *next* state, so a control line rises on the same edge that
// enters its state.
// ---------------------------------------------------------------------------
module dp_job_scheduler #(
  parameter int NREQ      = 2,
  parameter int STAGE_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            sel1,
  output logic            sel2,
  output logic            mux1,
  output logic            sel3,
  output logic            sel4,
  output logic            mux2,
  output logic [NREQ-1:0] done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic            sel1_q, sel1_d;
  logic            sel2_q, sel2_d;
  logic            mux1_q, mux1_d;
  logic            sel3_q, sel3_d;
  logic            sel4_q, sel4_d;
  logic            mux2_q, mux2_d;

  logic [PW-1:0]   winner;
  logic            found;
  logic [PW-1:0]   owner_inc;
  logic            stage_end;
  logic            owner_req;

  // Index arithmetic modulo NREQ. NREQ need not be a power of two, so the
  // wrap is explicit rather than relying on the vector width.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Round-robin search. Start at the pointer, move upward, and wrap. The
  // first request found wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[wrap_add(ptr_q, i)]) begin
        found  = 1'b1;
        winner = wrap_add(ptr_q, i);
      end
    end
  end

  assign owner_inc = wrap_add(owner_q, 1);
  assign stage_end = (cnt_q == 4'(STAGE_CYC - 1));
  assign owner_req = req[owner_q];

  // Next-state logic and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (found) begin
          state_d         = S1;
          owner_d         = winner;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
        end
      end
      S1, S2, S3, S4: begin
        if (!owner_req) begin
          // Abort: the owner dropped its request. Release the datapath
          // without a done pulse. The pointer still moves past the owner.
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = owner_inc;
          cnt_d   = 4'd0;
        end else if (stage_end) begin
          cnt_d = 4'd0;
          unique case (state_q)
            S1:      state_d = S2;
            S2:      state_d = S3;
            S3:      state_d = S4;
            default: state_d = FIN;
          endcase
        end
      end
      FIN: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = owner_inc;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = 4'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
    sel1_d = (state_d == S1);
    sel2_d = (state_d == S2);
    mux1_d = (state_d == S2);
    sel3_d = (state_d == S3);
    sel4_d = (state_d == S4);
    mux2_d = (state_d == S4);
    done_d = (state_d == FIN) ? grant_d : '0;
  end

  // State and output registers. Reset clears everything at once, so an
  // interrupted job never reaches FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      sel1_q  <= 1'b0;
      sel2_q  <= 1'b0;
      mux1_q  <= 1'b0;
      sel3_q  <= 1'b0;
      sel4_q  <= 1'b0;
      mux2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      sel1_q  <= sel1_d;
      sel2_q  <= sel2_d;
      mux1_q  <= mux1_d;
      sel3_q  <= sel3_d;
      sel4_q  <= sel4_d;
      mux2_q  <= mux2_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign sel1  = sel1_q;
  assign sel2  = sel2_q;
  assign mux1  = mux1_q;
  assign sel3  = sel3_q;
  assign sel4  = sel4_q;
  assign mux2  = mux2_q;

endmodule

// File: tb/tb_dp_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dp_job_scheduler
//
// Directed bench for dp_job_scheduler. Instance dutA uses NREQ=2 and
// STAGE_CYC=1. Instance dutB uses NREQ=2 and STAGE_CYC=3. Both share one
// clock and one reset. Each instance's outputs are packed as
//   {grant[1:0], busy, sel1, sel2, mux1, sel3, sel4, mux2, done[1:0]}
// and compared against the stage pattern that the decode table predicts.
// ---------------------------------------------------------------------------
module tb_dp_job_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] reqA = 2'b00;
  logic [1:0] reqB = 2'b00;

  logic [1:0] grantA, doneA, grantB, doneB;
  logic       busyA, sel1A, sel2A, mux1A, sel3A, sel4A, mux2A;
  logic       busyB, sel1B, sel2B, mux1B, sel3B, sel4B, mux2B;

  int errors = 0;
  int checks = 0;
  int doneCnt [2] = '{0, 0};

  wire [10:0] outA = {grantA, busyA, sel1A, sel2A, mux1A, sel3A, sel4A, mux2A, doneA};
  wire [10:0] outB = {grantB, busyB, sel1B, sel2B, mux1B, sel3B, sel4B, mux2B, doneB};

  dp_job_scheduler #(.NREQ(2), .STAGE_CYC(1)) dutA (
    .clk(clk), .rst_n(rst_n), .req(reqA), .grant(grantA), .busy(busyA),
    .sel1(sel1A), .sel2(sel2A), .mux1(mux1A), .sel3(sel3A), .sel4(sel4A),
    .mux2(mux2A), .done(doneA)
  );

  dp_job_scheduler #(.NREQ(2), .STAGE_CYC(3)) dutB (
    .clk(clk), .rst_n(rst_n), .req(reqB), .grant(grantB), .busy(busyB),
    .sel1(sel1B), .sel2(sel2B), .mux1(mux1B), .sel3(sel3B), .sel4(sel4B),
    .mux2(mux2B), .done(doneB)
  );

  always #5 clk = ~clk;

  // Expected packed outputs for stage st (0=IDLE, 1..4=S1..S4, 5=FIN)
  // with owner g.
  function automatic logic [10:0] expOut(input logic [1:0] g, input int st);
    logic [5:0] s;
    case (st)
      1:       s = 6'b100000;
      2:       s = 6'b011000;
      3:       s = 6'b000100;
      4:       s = 6'b000011;
      default: s = 6'b000000;
    endcase
    return {(st == 0) ? 2'b00 : g, (st != 0), s, (st == 5) ? g : 2'b00};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock. Sampling and driving happen 1 time unit after the
  // rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // A full STAGE_CYC=1 job on dutA: S1..S4, then FIN.
  task automatic runJob(input logic [1:0] g, input string tag);
    for (int st = 1; st <= 5; st++) begin
      applyStimulus();
      checkOutput(tag, 32'(outA), 32'(expOut(g, st)));
    end
  endtask

  initial begin
    $display("[TB] start");

    // Test 1: single requester 0.
    reqA = 2'b01;
    applyStimulus();
    applyStimulus();
    checkOutput("t1_reset", 32'(outA), 32'(expOut(2'b00, 0)));
    checkOutput("t1_resetB", 32'(outB), 32'(expOut(2'b00, 0)));
    rst_n = 1'b1;
    runJob(2'b01, "t1_job");
    reqA = 2'b00;
    applyStimulus();
    checkOutput("t1_idle", 32'(outA), 32'(expOut(2'b00, 0)));

    // Test 2: both requesters held. After a fresh reset the jobs go 01, 10, 01.
    rst_n = 1'b0;
    reqA  = 2'b11;
    applyStimulus();
    rst_n = 1'b1;
    runJob(2'b01, "t2_job0");
    applyStimulus();
    checkOutput("t2_gap0", 32'(outA), 32'(expOut(2'b00, 0)));
    runJob(2'b10, "t2_job1");
    applyStimulus();
    checkOutput("t2_gap1", 32'(outA), 32'(expOut(2'b00, 0)));
    runJob(2'b01, "t2_job2");
    reqA = 2'b00;
    applyStimulus();
    checkOutput("t2_gap2", 32'(outA), 32'(expOut(2'b00, 0)));

    // Test 4: abort during S3. The pointer still advances past requester 0.
    reqA = 2'b01;
    for (int st = 1; st <= 3; st++) begin
      applyStimulus();
      checkOutput("t4_run", 32'(outA), 32'(expOut(2'b01, st)));
    end
    reqA = 2'b00;
    applyStimulus();
    checkOutput("t4_abort", 32'(outA), 32'(expOut(2'b00, 0)));
    applyStimulus();
    checkOutput("t4_nodone", 32'(outA), 32'(expOut(2'b00, 0)));
    reqA = 2'b11;
    applyStimulus();
    checkOutput("t4_ptr", 32'(outA), 32'(expOut(2'b10, 1)));
    reqA = 2'b00;
    applyStimulus();
    checkOutput("t4_abort2", 32'(outA), 32'(expOut(2'b00, 0)));

    // Test 5: asynchronous reset during S2.
    reqA = 2'b01;
    applyStimulus();
    applyStimulus();
    checkOutput("t5_s2", 32'(outA), 32'(expOut(2'b01, 2)));
    #2 rst_n = 1'b0;
    #1 checkOutput("t5_async", 32'(outA), 32'(expOut(2'b00, 0)));
    applyStimulus();
    applyStimulus();
    checkOutput("t5_held", 32'(outA), 32'(expOut(2'b00, 0)));
    rst_n = 1'b1;
    reqA  = 2'b10;
    applyStimulus();
    checkOutput("t5_fresh", 32'(outA), 32'(expOut(2'b10, 1)));
    reqA = 2'b00;
    applyStimulus();
    checkOutput("t5_idle", 32'(outA), 32'(expOut(2'b00, 0)));

    // Test 3: STAGE_CYC=3 on dutB. Each stage lasts 3 cycles, and done comes 12 cycles in.
    reqB = 2'b10;
    for (int i = 0; i <= 12; i++) begin
      applyStimulus();
      checkOutput("t3_stage", 32'(outB), 32'(expOut(2'b10, i / 3 + 1)));
    end
    reqB = 2'b00;
    applyStimulus();
    checkOutput("t3_idle", 32'(outB), 32'(expOut(2'b00, 0)));

    // Test 6: random request streams on dutA, with invariants checked every cycle.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (doneA[b]) begin
          doneCnt[b]++;
          reqA[b] = 1'b0;
        end else if (!reqA[b]) begin
          reqA[b] = 1'($urandom_range(0, 1));
        end else if (grantA[b] && $urandom_range(0, 15) == 0) begin
          reqA[b] = 1'b0;
        end
      end
      applyStimulus();
      checkOutput("t6_sel", 32'($countones({sel1A, sel2A, sel3A, sel4A}) <= 1), 32'd1);
      checkOutput("t6_grant", 32'($countones(grantA) <= 1), 32'd1);
      checkOutput("t6_done", 32'((doneA == 2'b00) || (doneA == grantA)), 32'd1);
      checkOutput("t6_mux", 32'({mux1A, mux2A}), 32'({sel2A, sel4A}));
      checkOutput("t6_busy", 32'(busyA), 32'(grantA != 2'b00));
    end
    checkOutput("t6_starve0", 32'(doneCnt[0] > 0), 32'd1);
    checkOutput("t6_starve1", 32'(doneCnt[1] > 0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
